a23_cache_flush_ctrl: RTL and testbench



---
 rtl/a23_cache_pkg.sv | 14 +
 rtl/a23_cache_flush_ctrl.sv | 133 +++++++++++++
 tb/tb_a23_cache_flush_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/a23_cache_pkg.sv
// Shared definitions for the Amber 2 cache: flush FSM encoding and default geometry.
package a23_cache_pkg;

    typedef enum logic [1:0] {
        FlushInit = 2'd0,
        FlushIdle = 2'd1,
        FlushWalk = 2'd2,
        FlushDone = 2'd3
    } flush_state_e;

    localparam int unsigned CacheLinesDflt     = 256;
    localparam int unsigned CacheAddrWidthDflt = 8;

endpackage

// File: rtl/a23_cache_flush_ctrl.sv
// Tag-RAM invalidation sequencer: walks every set after reset, CP15 flush or cache disable.
// Define A23_FLUSH_COUNT_EN to build the saturating completed-walk counter.
module a23_cache_flush_ctrl
    import a23_cache_pkg::*;
#(
    parameter int unsigned CACHE_LINES      = CacheLinesDflt,
    parameter int unsigned CACHE_ADDR_WIDTH = CacheAddrWidthDflt
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_cache_flush,
    input  logic                        i_cache_enable,
    input  logic                        i_tag_stall,
    output logic                        o_tag_wr_en,
    output logic [CACHE_ADDR_WIDTH-1:0] o_tag_addr,
    output logic                        o_flush_busy,
    output logic                        o_flush_done,
    output logic [15:0]                 o_flush_count
);

    localparam logic [CACHE_ADDR_WIDTH-1:0] LastIdx = CACHE_ADDR_WIDTH'(CACHE_LINES - 1);

    flush_state_e                state_q, state_d;
    logic [CACHE_ADDR_WIDTH-1:0] idx_q, idx_d;
    logic                        pending_q, pending_d;
    logic                        enable_d1_q;
    logic                        trigger;

    logic                        busy_q, busy_d;
    logic                        wr_en_q, wr_en_d;
    logic [CACHE_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                        done_q, done_d;

    // A falling cache-enable bit is treated exactly like an explicit flush.
    assign trigger = i_cache_flush | (enable_d1_q & ~i_cache_enable);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pending_d = pending_q;

        case (state_q)
            FlushInit: begin
                state_d = FlushWalk;
                idx_d   = '0;
            end
            FlushIdle: begin
                if (trigger) begin
                    state_d = FlushWalk;
                    idx_d   = '0;
                end
            end
            FlushWalk: begin
                // Never restart a walk in progress; remember one more is owed.
                if (trigger) begin
                    pending_d = 1'b1;
                end
                if (!i_tag_stall) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_q == LastIdx) begin
                        state_d = FlushDone;
                    end
                end
            end
            FlushDone: begin
                state_d   = (pending_q | trigger) ? FlushWalk : FlushIdle;
                pending_d = 1'b0;
                idx_d     = '0;
            end
            default: begin
                state_d = FlushInit;
                idx_d   = '0;
            end
        endcase

        // Outputs are decoded from the next state so they can be registered.
        busy_d  = (state_d == FlushDone) ? pending_d : (state_d != FlushIdle);
        wr_en_d = (state_d == FlushWalk);
        addr_d  = idx_d;
        done_d  = (state_d == FlushDone);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= FlushInit;
            idx_q       <= '0;
            pending_q   <= 1'b0;
            enable_d1_q <= 1'b0;
            busy_q      <= 1'b1;
            wr_en_q     <= 1'b0;
            addr_q      <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            pending_q   <= pending_d;
            enable_d1_q <= i_cache_enable;
            busy_q      <= busy_d;
            wr_en_q     <= wr_en_d;
            addr_q      <= addr_d;
            done_q      <= done_d;
        end
    end

    assign o_tag_wr_en  = wr_en_q;
    assign o_tag_addr   = addr_q;
    assign o_flush_busy = busy_q;
    assign o_flush_done = done_q;

`ifdef A23_FLUSH_COUNT_EN
    logic [15:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if ((state_d == FlushDone) && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q <= 16'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_flush_count = count_q;
`else
    assign o_flush_count = 16'd0;
`endif

endmodule

// File: tb/tb_a23_cache_flush_ctrl.sv
// Scoreboard bench for a23_cache_flush_ctrl with a 16-set cache.
module tb_a23_cache_flush_ctrl;

    localparam int Lines = 16;
    localparam int AddrW = 4;

    typedef struct {
        int cyc;
        int addr;
    } wr_t;

    typedef struct {
        int cyc;
        int busy;
        int cnt;
    } done_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             en = 1'b1;
    logic             stall = 1'b0;
    logic             tag_wr_en;
    logic [AddrW-1:0] tag_addr;
    logic             busy;
    logic             done;
    logic [15:0]      count;

    wr_t   wq[$];
    done_t dq[$];
    wr_t   wr_e;
    done_t dn_e;
    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;

    a23_cache_flush_ctrl #(
        .CACHE_LINES      (Lines),
        .CACHE_ADDR_WIDTH (AddrW)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_cache_flush  (flush),
        .i_cache_enable (en),
        .i_tag_stall    (stall),
        .o_tag_wr_en    (tag_wr_en),
        .o_tag_addr     (tag_addr),
        .o_flush_busy   (busy),
        .o_flush_done   (done),
        .o_flush_count  (count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int exp_cnt(input int n);
`ifdef A23_FLUSH_COUNT_EN
        return n;
`else
        return 0 * n;
`endif
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a write or a done pulse.
    always @(negedge clk) begin
        if (tag_wr_en) begin
            if (wq.size() == 0) begin
                check("unexpected_write_addr", int'(tag_addr), -1);
            end else begin
                wr_e = wq.pop_front();
                check("wr_cycle", cyc, wr_e.cyc);
                check("wr_addr", int'(tag_addr), wr_e.addr);
                check("wr_busy", int'(busy), 1);
            end
        end else if (wq.size() != 0 && wq[0].cyc <= cyc) begin
            wr_e = wq.pop_front();
            check("missed_write_addr", -1, wr_e.addr);
        end
        if (done) begin
            if (dq.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                dn_e = dq.pop_front();
                check("done_cycle", cyc, dn_e.cyc);
                check("done_busy", int'(busy), dn_e.busy);
                check("done_count", int'(count), dn_e.cnt);
            end
        end else if (dq.size() != 0 && dq[0].cyc <= cyc) begin
            dn_e = dq.pop_front();
            check("missed_done_cycle", -1, dn_e.cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic push_walk(input int start, input int stall_addr, input int stall_len,
                             input int cnt, input int busy_after);
        int c;
        c = start;
        for (int a = 0; a < Lines; a++) begin
            int reps;
            reps = (a == stall_addr) ? stall_len + 1 : 1;
            for (int r = 0; r < reps; r++) begin
                wq.push_back('{c, a});
                c++;
            end
        end
        dq.push_back('{c, busy_after, cnt});
    endtask

    task automatic pulse_flush(output int n);
        flush = 1'b1;
        n = cyc;
        tick();
        flush = 1'b0;
    endtask

    task automatic drain(input int budget);
        int b;
        b = 0;
        while ((wq.size() != 0 || dq.size() != 0) && b < budget) begin
            tick();
            b++;
        end
        if (wq.size() != 0 || dq.size() != 0) begin
            check("drain_timeout_pending", wq.size() + dq.size(), 0);
            wq.delete();
            dq.delete();
        end
        tick();
    endtask

    initial begin
        int n;

        // Reset state, then the automatic INIT walk.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 1);
        check("rst_wr_en", int'(tag_wr_en), 0);
        check("rst_addr", int'(tag_addr), 0);
        check("rst_done", int'(done), 0);
        check("rst_count", int'(count), 0);
        rst = 1'b0;
        push_walk(cyc + 1, -1, 0, exp_cnt(1), 0);
        drain(40);
        tick();
        check("idle_busy", int'(busy), 0);
        check("idle_wr_en", int'(tag_wr_en), 0);

        // Explicit flush from IDLE.
        pulse_flush(n);
        push_walk(n + 1, -1, 0, exp_cnt(2), 0);
        drain(40);

        // Three-cycle stall while set 5 is presented.
        pulse_flush(n);
        push_walk(n + 1, 5, 3, exp_cnt(3), 0);
        wait_to(n + 6);
        stall = 1'b1;
        repeat (3) tick();
        stall = 1'b0;
        drain(40);

        // Two triggers mid-walk collapse into one extra back-to-back walk.
        pulse_flush(n);
        push_walk(n + 1, -1, 0, exp_cnt(4), 1);
        push_walk(n + 18, -1, 0, exp_cnt(5), 0);
        wait_to(n + 3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_to(n + 9);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drain(80);

        // Cache-enable falling edge starts a walk; rising edge does not.
        en = 1'b0;
        n = cyc;
        push_walk(n + 1, -1, 0, exp_cnt(6), 0);
        tick();
        drain(40);
        en = 1'b1;
        repeat (20) tick();
        check("enable_rise_busy", int'(busy), 0);
        check("enable_rise_wr_en", int'(tag_wr_en), 0);

        // Reset mid-walk at set 7 restarts from INIT with the counter cleared.
        pulse_flush(n);
        for (int a = 0; a < 8; a++) wq.push_back('{n + 1 + a, a});
        wait_to(n + 8);
        rst = 1'b1;
        tick();
        check("midrst_busy", int'(busy), 1);
        check("midrst_wr_en", int'(tag_wr_en), 0);
        check("midrst_addr", int'(tag_addr), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_count", int'(count), 0);
        check("midrst_writes_left", wq.size(), 0);
        rst = 1'b0;
        push_walk(cyc + 1, -1, 0, exp_cnt(1), 0);
        drain(40);
        repeat (3) tick();
        check("final_busy", int'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
